i2c_burst_reg_access: RTL and testbench
=======================================

Name: i2c_burst_reg_access

Overview:
- Parametrised successor to the single-register I2C access wrapper.
- Sequences a byte-level I2C master (ena/busy handshake) through 8- or 16-bit register addressing, multi-byte burst reads and writes, and automatic retry on NACK.
- Sits between the HDMI-transmitter/config control logic and the shared i2c_master instance.
- Write data is buffered internally, so retries need no re-supply. Read data is released only after a successful transaction.

Parameters:
- REG_ADDR_BYTES, 1, number of register address bytes sent MSB first (1 or 2).
- MAX_BURST, 8, buffer depth and maximum data bytes per transaction (1..16).
- RETRIES, 3, extra attempts after a NACK (0..7).
- RETRY_GAP, 1024, idle clk cycles between a failed attempt and its retry.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- chip_addr  in  7  7-bit device address, sampled on start
- reg_addr  in  16  register address, sampled on start; upper byte ignored when REG_ADDR_BYTES=1
- is_read  in  1  1=burst read, 0=burst write, sampled on start
- burst_len  in  clog2(MAX_BURST+1)  data byte count, sampled on start
- start  in  1  one-cycle request; honoured only when done=1
- wr_valid  in  1  pushes wr_data into buffer at wr_ptr (idle only)
- wr_data  in  8  write byte
- rd_valid  out  1  read byte strobe
- rd_data  out  8  read byte
- done  out  1  1 when idle
- ack_error  out  1  final attempt NACKed; valid while done=1
- m_ena  out  1  to master: transaction enable
- m_addr  out  7  to master: device address
- m_rw  out  1  to master: 1=read byte
- m_data_wr  out  8  to master: byte to write
- m_busy  in  1  from master
- m_data_rd  in  8  from master
- m_ack_error  in  1  from master

Behaviour:
- Reset (async): state IDLE; done=1, ack_error=0, rd_valid=0, m_ena=0, m_rw=0; rd_data, m_addr, m_data_wr=0; wr_ptr=0, retry count=0. Reset mid-transaction drops m_ena immediately; the master is left to finish on its own.
- IDLE, wr_valid: buffer[wr_ptr]<=wr_data; wr_ptr increments and saturates at MAX_BURST (further pushes ignored). wr_valid outside IDLE is ignored.
- IDLE, start: latch request; clamp burst_len 0 to 1 and >MAX_BURST to MAX_BURST. Next cycle: done=0, ack_error=0, wr_ptr=0, state ADDR.
- start while done=0 is ignored.
- Write command with fewer buffered bytes than burst_len: unwritten entries send 0x00.
- Command acceptance: each 0->1 edge of m_busy (registered m_busy_prev) means the master latched the presented byte. The next byte is presented in the cycle after that edge.
- ADDR: m_ena=1, m_addr=chip, m_rw=0; present reg addr bytes MSB first.
- After the last address byte is accepted:
  - write command: state WDATA; present buffer[0..n-1] with m_rw=0.
  - read command: state RDATA; m_rw=1 for n bytes.
- RDATA capture: byte k (k>=1) is captured from m_data_rd into buffer[k-1] on the busy rising edge that accepts byte k+1. The last byte is captured on the m_busy 1->0 edge.
- Ena release: on acceptance of the final byte, m_ena<=0 in the same cycle; state WAIT_END.
- WAIT_END: on the m_busy 1->0 edge, sample m_ack_error:
  - 0: success. Write command goes to FINISH. Read command goes to EMIT.
  - 1 with retries remaining: retry count increments, state GAP.
  - 1 with no retries remaining: ack_error=1, FINISH.
- GAP: count RETRY_GAP cycles with m_ena=0, then re-enter ADDR. The buffer pointer restarts at 0.
- EMIT: rd_valid=1 for n consecutive cycles with rd_data=buffer[0..n-1], then FINISH. No rd_valid is emitted for failed attempts.
- FINISH: done=1 next cycle, retry count=0, state IDLE.
- m_ack_error is ignored in every state except at the WAIT_END falling edge.
- Total attempts are at most RETRIES+1.

Test Plan:
- REG_ADDR_BYTES=2, write chip 0x39 reg 0x1234 burst 3 {AA,BB,CC}, master model ACKs -> m_data_wr sequence 12,34,AA,BB,CC all with m_rw=0; m_ena falls on the 5th busy rise; done=1 with ack_error=0.
- REG_ADDR_BYTES=1, read reg 0x42 burst 4; model returns 11,22,33,44 -> addr byte 42 with m_rw=0, then 4 accepts with m_rw=1; rd_valid for 4 consecutive cycles with rd_data 11,22,33,44, then done=1.
- RETRIES=2, model NACKs attempts 1 and 2 and ACKs attempt 3 -> three address phases each separated by >=RETRY_GAP idle cycles; ack_error=0; write data is identical on every attempt.
- RETRIES=1, model always NACKs a read -> exactly 2 attempts; ack_error=1, done=1, rd_valid never asserted.
- Boundaries: burst_len=0 sends 1 byte; burst_len=MAX_BURST+3 clamps to MAX_BURST; a 9th wr_valid push with MAX_BURST=8 is dropped; start during busy is ignored.
- Assert reset mid-WDATA -> m_ena=0, done=1 and ack_error=0 immediately; a new start after reset completes normally.

Source files
------------

// File: rtl/i2c_burst_reg_access.sv
// i2c_burst_reg_access: drives a byte-level I2C master through register-addressed burst
// reads/writes with buffered data and automatic retry on NACK.
module i2c_burst_reg_access #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_BURST = 8,
  parameter int RETRIES = 3,
  parameter int RETRY_GAP = 1024,
  localparam int BLW = $clog2(MAX_BURST + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [6:0]     chip_addr,
  input  logic [15:0]    reg_addr,
  input  logic           is_read,
  input  logic [BLW-1:0] burst_len,
  input  logic           start,
  input  logic           wr_valid,
  input  logic [7:0]     wr_data,
  output logic           rd_valid,
  output logic [7:0]     rd_data,
  output logic           done,
  output logic           ack_error,
  output logic           m_ena,
  output logic [6:0]     m_addr,
  output logic           m_rw,
  output logic [7:0]     m_data_wr,
  input  logic           m_busy,
  input  logic [7:0]     m_data_rd,
  input  logic           m_ack_error
);
  localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int IW = $clog2(REG_ADDR_BYTES + MAX_BURST + 1);
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam int RW = $clog2(RETRIES + 2);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, WAIT_END, GAP, EMIT, FINISH} state_t;
  state_t r_state, w_next;
  logic [7:0] r_buf [2**AW];
  logic r_busy_prev, r_is_read;
  logic [6:0] r_chip;
  logic [15:0] r_reg;
  logic [BLW-1:0] r_len, r_wcnt, r_wr_ptr, w_len;
  logic [IW-1:0] r_idx, w_pidx, w_didx;
  logic [RW-1:0] r_retry;
  logic [GW-1:0] r_gap;
  logic [AW-1:0] w_cidx;
  logic [7:0] w_pbyte;
  logic w_rise, w_fall, w_acc, w_addr_last, w_last, w_push, w_cap, w_prw;
  assign w_rise = m_busy & ~r_busy_prev;
  assign w_fall = ~m_busy & r_busy_prev;
  assign w_acc = m_ena & w_rise;
  assign w_addr_last = r_idx == IW'(REG_ADDR_BYTES - 1);
  assign w_last = r_idx == IW'(REG_ADDR_BYTES) + IW'(r_len) - IW'(1);
  assign w_len = burst_len == '0 ? BLW'(1) : burst_len > BLW'(MAX_BURST) ? BLW'(MAX_BURST) : burst_len;
  // index of the byte to present next: the current one before ena is raised, else the following one
  assign w_pidx = m_ena ? r_idx + IW'(1) : r_idx;
  assign w_didx = w_pidx - IW'(REG_ADDR_BYTES);
  assign w_prw = r_is_read & (w_pidx >= IW'(REG_ADDR_BYTES));
  assign w_pbyte = w_pidx >= IW'(REG_ADDR_BYTES)
                 ? ((r_is_read || w_didx >= IW'(r_wcnt)) ? 8'h00 : r_buf[AW'(w_didx)])
                 : (REG_ADDR_BYTES == 2 && w_pidx == '0) ? r_reg[15:8] : r_reg[7:0];
  assign w_push = r_state == IDLE && wr_valid && r_wr_ptr < BLW'(MAX_BURST);
  // read byte k lands when the master accepts byte k+1, the last one when busy falls
  assign w_cap = (r_state == RDATA && w_acc && r_idx > IW'(REG_ADDR_BYTES)) ||
                 (r_state == WAIT_END && w_fall && r_is_read);
  assign w_cidx = AW'(r_idx - IW'(REG_ADDR_BYTES) - IW'(r_state == RDATA));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         w_next = start ? ADDR : IDLE;
      ADDR:         w_next = (w_acc && w_addr_last) ? (r_is_read ? RDATA : WDATA) : ADDR;
      WDATA, RDATA: w_next = (w_acc && w_last) ? WAIT_END : r_state;
      WAIT_END:     w_next = !w_fall ? WAIT_END : !m_ack_error ? (r_is_read ? EMIT : FINISH)
                           : (r_retry < RW'(RETRIES)) ? GAP : FINISH;
      GAP:          w_next = (r_gap == GW'(RETRY_GAP - 1)) ? ADDR : GAP;
      EMIT:         w_next = (r_idx == IW'(r_len) - IW'(1)) ? FINISH : EMIT;
      default:      w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (w_push) r_buf[AW'(r_wr_ptr)] <= wr_data;
    else if (w_cap) r_buf[w_cidx] <= m_data_rd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_busy_prev <= 1'b0;
      r_is_read <= 1'b0;
      r_chip <= '0;
      r_reg <= '0;
      r_len <= '0;
      r_wcnt <= '0;
      r_wr_ptr <= '0;
      r_idx <= '0;
      r_retry <= '0;
      r_gap <= '0;
      done <= 1'b1;
      ack_error <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      m_ena <= 1'b0;
      m_addr <= '0;
      m_rw <= 1'b0;
      m_data_wr <= '0;
    end else begin
      r_state <= w_next;
      r_busy_prev <= m_busy;
      rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_push) r_wr_ptr <= r_wr_ptr + BLW'(1);
          if (start) begin
            r_chip <= chip_addr;
            r_reg <= reg_addr;
            r_is_read <= is_read;
            r_len <= w_len;
            r_wcnt <= r_wr_ptr;
            r_wr_ptr <= '0;
            r_idx <= '0;
            done <= 1'b0;
            ack_error <= 1'b0;
          end
        end
        ADDR, WDATA, RDATA:
          if (!m_ena) begin
            m_ena <= 1'b1;
            m_addr <= r_chip;
            m_rw <= w_prw;
            m_data_wr <= w_pbyte;
          end else if (w_rise) begin
            if (w_last) m_ena <= 1'b0;
            else begin
              r_idx <= r_idx + IW'(1);
              m_rw <= w_prw;
              m_data_wr <= w_pbyte;
            end
          end
        WAIT_END:
          if (w_fall) begin
            r_idx <= '0;
            r_gap <= '0;
            if (w_next == GAP) r_retry <= r_retry + RW'(1);
            ack_error <= w_next == FINISH && m_ack_error;
          end
        GAP: r_gap <= r_gap + GW'(1);
        EMIT: begin
          rd_valid <= 1'b1;
          rd_data <= r_buf[AW'(r_idx)];
          r_idx <= r_idx + IW'(1);
        end
        default: begin
          done <= 1'b1;
          r_retry <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_i2c_burst_reg_access.sv
// tb_i2c_burst_reg_access: directed bench with a byte-level master model (busy pulse per byte).
module tb_i2c_burst_reg_access;
  localparam int RG = 20;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] chip_addr = '0, m_addr;
  logic [15:0] reg_addr = '0;
  logic is_read = 1'b0, start = 1'b0, wr_valid = 1'b0;
  logic [3:0] burst_len = '0;
  logic [7:0] wr_data = '0, rd_data, m_data_wr, m_data_rd = '0;
  logic rd_valid, done, ack_error, m_ena, m_rw;
  logic m_busy = 1'b0, m_ack_error = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] log_d[$], exp_q[$], rd_q[$];
  logic [6:0] log_a[$];
  logic log_rw[$];
  int rd_c[$];
  logic [7:0] rd_vals [4];

  i2c_burst_reg_access #(.REG_ADDR_BYTES(2), .MAX_BURST(8), .RETRIES(2), .RETRY_GAP(RG)) dut (
    .clk(clk), .reset(reset), .chip_addr(chip_addr), .reg_addr(reg_addr), .is_read(is_read),
    .burst_len(burst_len), .start(start), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .ack_error(ack_error),
    .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
    .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rd_valid) begin rd_q.push_back(rd_data); rd_c.push_back(cyc); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    log_d.delete(); log_a.delete(); log_rw.delete(); rd_q.delete(); rd_c.delete();
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk); wr_valid = 1'b1; wr_data = d;
    @(negedge clk); wr_valid = 1'b0;
  endtask

  task automatic kick(input logic [6:0] c, input logic [15:0] r, input logic rd, input logic [3:0] len);
    @(negedge clk); chip_addr = c; reg_addr = r; is_read = rd; burst_len = len; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // one attempt: a busy pulse per byte while ena stays high; max_b stops early leaving busy high
  task automatic serve(input bit nack, input int max_b, output int n, output int gap);
    int ri;
    ri = 0; n = 0; gap = 0;
    while (!m_ena && gap < 400) begin @(negedge clk); gap++; end
    chk("ena_wait", m_ena, 1);
    while (m_ena && n < max_b) begin
      log_a.push_back(m_addr); log_rw.push_back(m_rw); log_d.push_back(m_data_wr);
      if (n == 0) m_ack_error = 1'b0;
      m_busy = 1'b1; n++;
      repeat (3) @(negedge clk);
      if (n == max_b) return;
      if (log_rw[$] && ri < 4) begin m_data_rd = rd_vals[ri]; ri++; end
      if (!m_ena) m_ack_error = nack;
      m_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin @(negedge clk); k++; end
    chk(tag, done, 1);
  endtask

  task automatic chk_log(input string tag, input logic [6:0] c, input bit rd, input int nb);
    chk({tag, "_len"}, log_d.size(), nb);
    for (int i = 0; i < nb && i < log_d.size(); i++) begin
      chk({tag, "_addr"}, log_a[i], c);
      chk({tag, "_rw"}, log_rw[i], (rd && i >= 2) ? 1 : 0);
      if (!rd || i < 2) chk({tag, "_data"}, log_d[i], exp_q[i]);
    end
  endtask

  initial begin
    int n, g;
    logic any;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1);
    chk("rst_ackerr", ack_error, 0);
    chk("rst_ena", m_ena, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rw", m_rw, 0);
    chk("rst_dwr", m_data_wr, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_rdd", rd_data, 0);
    reset = 1'b0;

    clr(); push(8'hAA); push(8'hBB); push(8'hCC);
    kick(7'h39, 16'h1234, 1'b0, 4'd3);
    chk("w_busy", done, 0);
    kick(7'h11, 16'hBEEF, 1'b1, 4'd2);
    serve(1'b0, 100, n, g);
    chk("w_bytes", n, 5);
    exp_q = '{8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC};
    chk_log("w", 7'h39, 1'b0, 5);
    wait_done("w_done");
    chk("w_ackerr", ack_error, 0);
    chk("w_ena_low", m_ena, 0);
    chk("w_no_rdv", rd_q.size(), 0);

    clr(); rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    kick(7'h50, 16'h0042, 1'b1, 4'd4);
    serve(1'b0, 100, n, g);
    exp_q = '{8'h00, 8'h42};
    chk_log("r", 7'h50, 1'b1, 6);
    wait_done("r_done");
    chk("r_count", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      chk("r_data", rd_q[i], rd_vals[i]);
      chk("r_consec", rd_c[i] - rd_c[0], i);
    end
    chk("r_ackerr", ack_error, 0);

    clr(); push(8'h5A); push(8'hA5);
    kick(7'h3C, 16'h00FF, 1'b0, 4'd2);
    exp_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5};
    serve(1'b1, 100, n, g);
    chk_log("t1", 7'h3C, 1'b0, 4);
    chk("t_busy", done, 0);
    clr(); serve(1'b1, 100, n, g);
    chk("t2_gap", g >= RG, 1);
    chk_log("t2", 7'h3C, 1'b0, 4);
    clr(); serve(1'b0, 100, n, g);
    chk("t3_gap", g >= RG, 1);
    chk_log("t3", 7'h3C, 1'b0, 4);
    wait_done("t_done");
    chk("t_ackerr", ack_error, 0);

    clr(); rd_vals = '{8'h91, 8'h92, 8'h93, 8'h94};
    kick(7'h20, 16'h0101, 1'b1, 4'd2);
    for (int a = 0; a < 3; a++) begin
      serve(1'b1, 100, n, g);
      chk("nk_bytes", n, 4);
    end
    wait_done("nk_done");
    chk("nk_ackerr", ack_error, 1);
    any = 1'b0;
    repeat (3 * RG) begin @(negedge clk); any |= m_ena; end
    chk("nk_no_4th", any, 0);
    chk("nk_no_rdv", rd_q.size(), 0);

    clr(); push(8'h77);
    kick(7'h39, 16'hAB10, 1'b0, 4'd0);
    chk("b0_ackclr", ack_error, 0);
    serve(1'b0, 100, n, g);
    exp_q = '{8'hAB, 8'h10, 8'h77};
    chk_log("b0", 7'h39, 1'b0, 3);
    wait_done("b0_done");

    clr();
    for (int i = 1; i <= 9; i++) push(8'(i));
    kick(7'h39, 16'hAB10, 1'b0, 4'd11);
    serve(1'b0, 100, n, g);
    exp_q = '{8'hAB, 8'h10};
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    chk_log("cl", 7'h39, 1'b0, 10);
    wait_done("cl_done");

    clr(); push(8'hC1); push(8'hC2);
    kick(7'h39, 16'hAB10, 1'b0, 4'd4);
    serve(1'b0, 100, n, g);
    exp_q = '{8'hAB, 8'h10, 8'hC1, 8'hC2, 8'h00, 8'h00};
    chk_log("sh", 7'h39, 1'b0, 6);
    wait_done("sh_done");

    clr(); push(8'hD1); push(8'hD2); push(8'hD3);
    kick(7'h39, 16'hAB10, 1'b0, 4'd3);
    serve(1'b0, 3, n, g);
    chk("rs_pre_ena", m_ena, 1);
    reset = 1'b1;
    #1;
    chk("rs_ena", m_ena, 0);
    chk("rs_done", done, 1);
    chk("rs_ackerr", ack_error, 0);
    @(negedge clk); reset = 1'b0; m_busy = 1'b0; m_ack_error = 1'b0;
    repeat (2) @(negedge clk);
    clr(); push(8'hE1); push(8'hE2);
    kick(7'h39, 16'hAB10, 1'b0, 4'd2);
    serve(1'b0, 100, n, g);
    exp_q = '{8'hAB, 8'h10, 8'hE1, 8'hE2};
    chk_log("rs2", 7'h39, 1'b0, 4);
    wait_done("rs2_done");
    chk("rs2_ackerr", ack_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
